formula_nested_sqrt_fsm: RTL

// - Computes res = isqrt(arg[0] + isqrt(arg[1] + ... + isqrt(arg[N_TERMS-1]))) over N_TERMS nested terms.
// - Uses one shared external isqrt unit. Its latency is arbitrary but fixed, and it keeps at most one request outstanding.
// - Parametrised successor of the 3-term formula FSMs:
//   - generic depth and width;
//   - input back-pressure (arg_rdy);
//   - a result register that holds its value between computations.
//

---
 rtl/formula_fsm_pkg.sv | 7 +
 rtl/formula_nested_sqrt_fsm.sv | 67 ++++++
 2 files changed

// File: rtl/formula_fsm_pkg.sv
// formula_fsm_pkg: shared state encoding and sizing helpers for the nested-sqrt formula FSM
package formula_fsm_pkg;
  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} nested_sqrt_state_t;
  function automatic int idx_w(input int n);
    return $clog2(n > 1 ? n : 2);
  endfunction
endpackage

// File: rtl/formula_nested_sqrt_fsm.sv
// formula_nested_sqrt_fsm: isqrt(arg[0] + isqrt(arg[1] + ... isqrt(arg[N-1]))) over one shared isqrt unit
module formula_nested_sqrt_fsm
  import formula_fsm_pkg::*;
#(
  parameter int N_TERMS = 3,
  parameter int W       = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arg_vld,
  output logic                        arg_rdy,
  input  logic [N_TERMS-1:0][W-1:0]   arg,
  output logic                        res_vld,
  output logic [W-1:0]                res,
  output logic                        busy,
  output logic                        isqrt_x_vld,
  output logic [W-1:0]                isqrt_x,
  input  logic                        isqrt_y_vld,
  input  logic [W/2-1:0]              isqrt_y
);
  localparam int IW = idx_w(N_TERMS);
  nested_sqrt_state_t state, state_d;
  logic [IW-1:0] idx, idx_d;
  logic [N_TERMS-1:0][W-1:0] arg_q;
  logic [W-1:0] y_ext;
  logic done;
  assign y_ext = {{(W/2){1'b0}}, isqrt_y};
  // idx walks from the innermost term outwards; the next operand is formed the cycle the result lands
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    arg_rdy     = state == ST_IDLE;
    busy        = state == ST_WAIT;
    isqrt_x_vld = 1'b0;
    isqrt_x     = arg[N_TERMS-1];
    done        = 1'b0;
    if (state == ST_IDLE && arg_vld) begin
      isqrt_x_vld = 1'b1;
      idx_d       = IW'(N_TERMS - 1);
      state_d     = ST_WAIT;
    end else if (state == ST_WAIT && isqrt_y_vld) begin
      if (idx != '0) begin
        isqrt_x_vld = 1'b1;
        isqrt_x     = arg_q[idx - 1'b1] + y_ext;
        idx_d       = idx - 1'b1;
      end else begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      arg_q   <= '0;
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      res_vld <= done;
      if (done) res <= y_ext;
      if (state == ST_IDLE && arg_vld) arg_q <= arg;
    end
  end
endmodule
